driver_motoare_pwm: RTL and testbench

Motor-side counterpart of the movement logic. Consumes per-motor direction codes and 3-digit BCD duty factors, and generates glitch-free H-bridge controls for drivers A and B: `in1`/`in2` direction pins and a PWM enable. A dead-time interval is inserted on every change away from a driving direction. Duty values take effect only at PWM period boundaries.

---
 rtl/driver_motoare_pwm_if.sv | 16 +
 rtl/driver_motoare_pwm.sv | 80 ++++++++
 tb/tb_driver_motoare_pwm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/driver_motoare_pwm_if.sv
// driver_motoare_pwm_if: motor command inputs (directie/factor_dc) and H-bridge outputs (in1/in2/en/mort/perioada_start)
interface driver_motoare_pwm_if;
  logic [1:0] directie_driverA, directie_driverB;
  logic [11:0] factor_dc_driverA, factor_dc_driverB;
  logic in1_A, in2_A, en_A, mort_A;
  logic in1_B, in2_B, en_B, mort_B;
  logic perioada_start;
  modport master (
    output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
    input in1_A, in2_A, en_A, mort_A, in1_B, in2_B, en_B, mort_B, perioada_start
  );
  modport slave (
    input directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
    output in1_A, in2_A, en_A, mort_A, in1_B, in2_B, en_B, mort_B, perioada_start
  );
endinterface

// File: rtl/driver_motoare_pwm.sv
// driver_motoare_pwm: two-channel H-bridge driver with BCD PWM and dead time; ports clk, rst_n (async low), bus (slave: commands in, bridge controls out)
module driver_motoare_pwm #(
  parameter int PRESCALE = 50,
  parameter int DEAD_CYC = 1000
) (
  input logic clk,
  input logic rst_n,
  driver_motoare_pwm_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int TW = DEAD_CYC > 1 ? $clog2(DEAD_CYC) : 1;
  localparam logic [1:0] STOP = 2'd0, FWD = 2'd1, REV = 2'd2, DEAD = 2'd3;
  logic [PW-1:0] psc;
  logic [11:0] cnt, cnt_nx;
  logic tick, wrap, per;
  logic [1:0][1:0] dir_s, st;
  logic [1:0][11:0] duty_s, duty_sh;
  logic [1:0][TW-1:0] tmr;
  logic [1:0] in1, in2, en, mort;
  function automatic logic [11:0] clamp(input logic [11:0] d);
    return (d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) ? 12'h999 : d;
  endfunction
  function automatic logic [1:0] sel(input logic [1:0] d);
    return d == 2'b10 ? FWD : d == 2'b01 ? REV : STOP;
  endfunction
  function automatic logic [3:0] dinc(input logic [3:0] d);
    return d == 4'd9 ? 4'd0 : d + 4'd1;
  endfunction
  assign tick = psc == PW'(PRESCALE - 1);
  assign wrap = tick && cnt == 12'h999;
  assign cnt_nx = {cnt[7:0] == 8'h99 ? dinc(cnt[11:8]) : cnt[11:8],
                   cnt[3:0] == 4'h9 ? dinc(cnt[7:4]) : cnt[7:4],
                   dinc(cnt[3:0])};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psc <= '0;
      cnt <= '0;
      per <= 1'b0;
      dir_s <= '0;
      duty_s <= '0;
      duty_sh <= '0;
      st <= '0;
      tmr <= '0;
      in1 <= '0;
      in2 <= '0;
      en <= '0;
      mort <= '0;
    end else begin
      dir_s <= {bus.directie_driverB, bus.directie_driverA};
      duty_s <= {bus.factor_dc_driverB, bus.factor_dc_driverA};
      psc <= tick ? '0 : psc + 1'b1;
      cnt <= tick ? cnt_nx : cnt;
      per <= wrap;
      for (int c = 0; c < 2; c++) begin
        if (wrap) duty_sh[c] <= clamp(duty_s[c]);
        in1[c] <= st[c] == FWD;
        in2[c] <= st[c] == REV;
        en[c] <= (st[c] == FWD || st[c] == REV) && cnt < duty_sh[c];
        mort[c] <= st[c] == DEAD;
        if (st[c] == DEAD) begin
          tmr[c] <= tmr[c] == '0 ? '0 : tmr[c] - 1'b1;
          if (tmr[c] == '0) st[c] <= sel(dir_s[c]);
        end else if (st[c] == STOP) begin
          st[c] <= sel(dir_s[c]);
        end else if (dir_s[c] != (st[c] == FWD ? 2'b10 : 2'b01)) begin
          st[c] <= DEAD;
          tmr[c] <= TW'(DEAD_CYC - 1);
        end
      end
    end
  assign bus.in1_A = in1[0];
  assign bus.in2_A = in2[0];
  assign bus.en_A = en[0];
  assign bus.mort_A = mort[0];
  assign bus.in1_B = in1[1];
  assign bus.in2_B = in2[1];
  assign bus.en_B = en[1];
  assign bus.mort_B = mort[1];
  assign bus.perioada_start = per;
endmodule

// File: tb/tb_driver_motoare_pwm.sv
// tb_driver_motoare_pwm: directed plus randomized checks of driver_motoare_pwm against a timestamp-based reference model
module tb_driver_motoare_pwm;
  localparam int P = 2, D = 4, PER = 1000 * P;
  typedef enum logic [1:0] {M_STOP, M_FWD, M_REV, M_DEAD} mode_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cmp = 0, fails = 0;
  driver_motoare_pwm_if bus();
  driver_motoare_pwm #(.PRESCALE(P), .DEAD_CYC(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int k;
  mode_t mode [2];
  int dfrom [2], sh [2];
  logic [1:0] scmd [2];
  logic [11:0] sduty [2];
  logic e_in1 [2], e_in2 [2], e_en [2], e_mort [2];
  logic e_per;
  function automatic int duty_val(input logic [11:0] d);
    int h = int'(d[11:8]), t = int'(d[7:4]), u = int'(d[3:0]);
    return (h > 9 || t > 9 || u > 9) ? 999 : h * 100 + t * 10 + u;
  endfunction
  function automatic mode_t want(input logic [1:0] cmd);
    return cmd == 2'b10 ? M_FWD : cmd == 2'b01 ? M_REV : M_STOP;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      e_per <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        mode[c] <= M_STOP;
        dfrom[c] <= 0;
        sh[c] <= 0;
        scmd[c] <= 2'b00;
        sduty[c] <= 12'h000;
        e_in1[c] <= 1'b0;
        e_in2[c] <= 1'b0;
        e_en[c] <= 1'b0;
        e_mort[c] <= 1'b0;
      end
    end else begin
      k <= k + 1;
      e_per <= (k + 1) % PER == 0;
      for (int c = 0; c < 2; c++) begin
        e_in1[c] <= mode[c] == M_FWD;
        e_in2[c] <= mode[c] == M_REV;
        e_mort[c] <= mode[c] == M_DEAD;
        e_en[c] <= (mode[c] == M_FWD || mode[c] == M_REV) && (k / P) % 1000 < sh[c];
        if ((k + 1) % PER == 0) sh[c] <= duty_val(sduty[c]);
        if (mode[c] == M_STOP) mode[c] <= want(scmd[c]);
        else if (mode[c] == M_DEAD) begin
          if (k + 1 - dfrom[c] >= D) mode[c] <= want(scmd[c]);
        end else if (mode[c] != want(scmd[c])) begin
          mode[c] <= M_DEAD;
          dfrom[c] <= k + 1;
        end
      end
      scmd[0] <= bus.directie_driverA;
      scmd[1] <= bus.directie_driverB;
      sduty[0] <= bus.factor_dc_driverA;
      sduty[1] <= bus.factor_dc_driverB;
    end
  end
  task automatic chk(input string tag, input logic obs, input logic exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chki(input string tag, input int obs, input int exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] rnd_duty();
    return $urandom_range(0, 3) == 0 ? 12'($urandom) :
      {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction
  task automatic tick_chk();
    @(negedge clk);
    chk("in1_A", bus.in1_A, e_in1[0]);
    chk("in2_A", bus.in2_A, e_in2[0]);
    chk("en_A", bus.en_A, e_en[0]);
    chk("mort_A", bus.mort_A, e_mort[0]);
    chk("in1_B", bus.in1_B, e_in1[1]);
    chk("in2_B", bus.in2_B, e_in2[1]);
    chk("en_B", bus.en_B, e_en[1]);
    chk("mort_B", bus.mort_B, e_mort[1]);
    chk("perioada_start", bus.perioada_start, e_per);
    chk("excl_A", bus.in1_A & bus.in2_A, 1'b0);
    chk("excl_B", bus.in1_B & bus.in2_B, 1'b0);
    if ($urandom_range(0, 149) == 0) bus.directie_driverB = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 299) == 0) bus.factor_dc_driverB = rnd_duty();
  endtask
  task automatic period(input logic [11:0] nxt, input int exp_hi, input string tag);
    int hi = 0;
    bus.factor_dc_driverA = nxt;
    for (int i = 0; i < PER; i++) begin
      tick_chk();
      hi += int'(bus.en_A);
    end
    chki(tag, hi, exp_hi);
    chk({tag, "_wrap"}, bus.perioada_start, 1'b1);
  endtask
  initial begin
    int n, hi;
    bus.directie_driverA = 2'b10;
    bus.factor_dc_driverA = 12'h500;
    bus.directie_driverB = 2'b00;
    bus.factor_dc_driverB = 12'h000;
    repeat (4) tick_chk();
    chk("rst_in1_A", bus.in1_A, 1'b0);
    chk("rst_en_A", bus.en_A, 1'b0);
    chk("rst_mort_A", bus.mort_A, 1'b0);
    chk("rst_per", bus.perioada_start, 1'b0);
    bus.factor_dc_driverA = 12'h250;
    rst_n = 1'b1;
    n = 0;
    do begin
      tick_chk();
      n++;
    end while (!bus.perioada_start && n < 3000);
    chki("first_period", n, PER);
    period(12'h000, 500, "duty250");
    period(12'h9A0, 0, "duty000");
    period(12'h100, 1998, "clamp");
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == PER / 2) bus.factor_dc_driverA = 12'h800;
      tick_chk();
      hi += int'(bus.en_A);
    end
    chki("mid_old", hi, 200);
    period(12'h800, 1600, "mid_new");
    bus.directie_driverA = 2'b01;
    for (int j = 0; j <= 7; j++) begin
      tick_chk();
      chk("rev_in1", bus.in1_A, j < 2);
      chk("rev_in2", bus.in2_A, j >= 6);
      chk("rev_mort", bus.mort_A, j >= 2 && j <= 5);
    end
    bus.directie_driverA = 2'b10;
    repeat (10) tick_chk();
    chk("back_fwd", bus.in1_A, 1'b1);
    bus.directie_driverA = 2'b01;
    for (int j = 0; j <= 9; j++) begin
      tick_chk();
      if (j == 0) bus.directie_driverA = 2'b10;
      chk("glitch_in1", bus.in1_A, j < 2 || j >= 6);
      chk("glitch_in2", bus.in2_A, 1'b0);
      chk("glitch_mort", bus.mort_A, j >= 2 && j <= 5);
    end
    bus.directie_driverA = 2'b01;
    for (int j = 0; j <= 9; j++) begin
      tick_chk();
      if (j == 0) bus.directie_driverA = 2'b00;
      chk("stop_in1", bus.in1_A, j < 2);
      chk("stop_in2", bus.in2_A, 1'b0);
      chk("stop_mort", bus.mort_A, j >= 2 && j <= 5);
    end
    bus.directie_driverA = 2'b10;
    repeat (6) tick_chk();
    bus.directie_driverA = 2'b01;
    repeat (4) tick_chk();
    chk("pre_rst_mort", bus.mort_A, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_dead_mort", bus.mort_A, 1'b0);
    chk("rst_dead_in1", bus.in1_A, 1'b0);
    chk("rst_dead_in2", bus.in2_A, 1'b0);
    chk("rst_dead_en", bus.en_A, 1'b0);
    repeat (2) tick_chk();
    rst_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick_chk();
      chk("rel_in2", bus.in2_A, j >= 3);
      chk("rel_mort", bus.mort_A, 1'b0);
    end
    repeat (10) begin
      bus.directie_driverA = 2'($urandom_range(0, 3));
      bus.factor_dc_driverA = rnd_duty();
      n = int'($urandom_range(100, 1500));
      repeat (n) tick_chk();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
